// File: rtl/pic16_seq_pkg.sv
// pic16_seq_pkg: shared phase/control encodings and default sizes for the fetch sequencer
package pic16_seq_pkg;
  localparam int PC_WIDTH_DEF = 13;
  localparam int OPCODE_WIDTH_DEF = 14;
  localparam int ROM_DEPTH_DEF = 1024;
  localparam int STACK_DEPTH_DEF = 8;
  localparam logic [13:0] PIC16_NOP = 14'h0000;
  typedef enum logic [2:0] {PH_IDLE, PH_Q1, PH_Q2, PH_Q3, PH_Q4} phase_e;
  typedef enum logic [2:0] {CTL_NONE, CTL_SKIP, CTL_GOTO, CTL_CALL, CTL_RETURN} ctl_e;
  function automatic phase_e phase_next(input phase_e p);
    return (p == PH_Q4) ? PH_Q1 : phase_e'(p + 3'd1);
  endfunction
  function automatic ctl_e ctl_decode(input logic ret, input logic call, input logic go, input logic skip);
    return ret ? CTL_RETURN : call ? CTL_CALL : go ? CTL_GOTO : skip ? CTL_SKIP : CTL_NONE;
  endfunction
endpackage

// File: rtl/pic16_hw_stack.sv
// pic16_hw_stack: circular return-address LIFO; status flags built in with PIC16_STACK_STATUS_EN
module pic16_hw_stack import pic16_seq_pkg::*; #(
  parameter int W = PC_WIDTH_DEF,
  parameter int DEPTH = STACK_DEPTH_DEF
) (
  input  logic         clk,
  input  logic         mclr,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] data_o
`ifdef PIC16_STACK_STATUS_EN
  ,
  output logic         stk_ovf_o,
  output logic         stk_unf_o
`endif
);
  localparam int PW = $clog2(DEPTH);
  logic [PW-1:0] ptr_q;
  logic [W-1:0] mem_q [DEPTH];
  assign data_o = mem_q[ptr_q - PW'(1)];
  // Pointer wraps both ways, so overflow overwrites the oldest entry and underflow rereads the wrapped slot
  always_ff @(posedge clk or negedge mclr) begin
    if (!mclr) begin
      ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push_i) begin
      mem_q[ptr_q] <= data_i;
      ptr_q <= ptr_q + PW'(1);
    end else if (pop_i) begin
      ptr_q <= ptr_q - PW'(1);
    end
  end
`ifdef PIC16_STACK_STATUS_EN
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
  localparam logic [PW:0] ONE = (PW+1)'(1);
  logic [PW:0] cnt_q;
  logic ovf_q, unf_q;
  assign stk_ovf_o = ovf_q;
  assign stk_unf_o = unf_q;
  // Saturating occupancy count drives sticky overflow/underflow flags
  always_ff @(posedge clk or negedge mclr) begin
    if (!mclr) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else if (push_i) begin
      ovf_q <= ovf_q | (cnt_q == FULL);
      cnt_q <= (cnt_q == FULL) ? cnt_q : cnt_q + ONE;
    end else if (pop_i) begin
      unf_q <= unf_q | (cnt_q == '0);
      cnt_q <= (cnt_q == '0) ? cnt_q : cnt_q - ONE;
    end
  end
`endif
endmodule

// File: rtl/pic16_fetch_sequencer.sv
// pic16_fetch_sequencer: Q1-Q4 phase generator, PC, program ROM and fetch/execute IR; PIC16_STACK_STATUS_EN adds stk_ovf/stk_unf
module pic16_fetch_sequencer import pic16_seq_pkg::*; #(
  parameter int PC_WIDTH = PC_WIDTH_DEF,
  parameter int OPCODE_WIDTH = OPCODE_WIDTH_DEF,
  parameter int ROM_DEPTH = ROM_DEPTH_DEF,
  parameter int STACK_DEPTH = STACK_DEPTH_DEF
) (
  input  logic                          clk,
  input  logic                          mclr,
  input  logic                          prog_we,
  input  logic [$clog2(ROM_DEPTH)-1:0]  prog_addr,
  input  logic [OPCODE_WIDTH-1:0]       prog_data,
  input  logic                          ctl_goto,
  input  logic                          ctl_call,
  input  logic                          ctl_return,
  input  logic                          ctl_skip,
  input  logic [PC_WIDTH-1:0]           ctl_target,
  output logic                          q1,
  output logic                          q2,
  output logic                          q3,
  output logic                          q4,
  output logic [PC_WIDTH-1:0]           pc_out,
  output logic [OPCODE_WIDTH-1:0]       op_code,
  output logic                          nop_out
`ifdef PIC16_STACK_STATUS_EN
  ,
  output logic                          stk_ovf,
  output logic                          stk_unf
`endif
);
  localparam int AW = $clog2(ROM_DEPTH);
  logic [OPCODE_WIDTH-1:0] rom_q [ROM_DEPTH];
  phase_e ph_q, ph_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d, stk_top;
  logic [OPCODE_WIDTH-1:0] ir_q, ir_d;
  logic nop_q, nop_d, push, pop;
  ctl_e ctl;
  assign {q1, q2, q3, q4} = {ph_q == PH_Q1, ph_q == PH_Q2, ph_q == PH_Q3, ph_q == PH_Q4};
  assign pc_out = pc_q;
  assign op_code = ir_q;
  assign nop_out = nop_q;
  pic16_hw_stack #(.W(PC_WIDTH), .DEPTH(STACK_DEPTH)) u_stack (
    .clk(clk),
    .mclr(mclr),
    .push_i(push),
    .pop_i(pop),
    .data_i(pc_q),
    .data_o(stk_top)
`ifdef PIC16_STACK_STATUS_EN
    ,
    .stk_ovf_o(stk_ovf),
    .stk_unf_o(stk_unf)
`endif
  );
  // Program store has no reset so contents survive master clear; reads see the pre-write word
  always_ff @(posedge clk) begin
    if (prog_we) rom_q[prog_addr] <= prog_data;
  end
  // Q4 is the only phase that fetches, advances the PC or honours branch requests
  always_comb begin
    ph_d = phase_next(ph_q);
    ctl = ctl_decode(ctl_return, ctl_call, ctl_goto, ctl_skip);
    pc_d = pc_q;
    ir_d = ir_q;
    nop_d = nop_q;
    push = 1'b0;
    pop = 1'b0;
    if (ph_q == PH_Q4) begin
      pc_d = (ctl == CTL_RETURN) ? stk_top :
             (ctl == CTL_CALL || ctl == CTL_GOTO) ? ctl_target : pc_q + PC_WIDTH'(1);
      ir_d = (ctl == CTL_NONE) ? rom_q[pc_q[AW-1:0]] : OPCODE_WIDTH'(PIC16_NOP);
      nop_d = ctl != CTL_NONE;
      push = ctl == CTL_CALL;
      pop = ctl == CTL_RETURN;
    end
  end
  // Master clear parks the phase in idle so the first edge after release lands in Q1
  always_ff @(posedge clk or negedge mclr) begin
    if (!mclr) begin
      ph_q <= PH_IDLE;
      pc_q <= '0;
      ir_q <= '0;
      nop_q <= 1'b1;
    end else begin
      ph_q <= ph_d;
      pc_q <= pc_d;
      ir_q <= ir_d;
      nop_q <= nop_d;
    end
  end
endmodule

// File: tb/tb_pic16_fetch_sequencer.sv
// tb_pic16_fetch_sequencer: directed stimulus with an instruction-level reference model and per-cycle compare
module tb_pic16_fetch_sequencer;
  logic clk = 1'b0;
  logic mclr = 1'b0;
  logic prog_we = 1'b0;
  logic [9:0] prog_addr = '0;
  logic [13:0] prog_data = '0;
  logic ctl_goto = 1'b0, ctl_call = 1'b0, ctl_return = 1'b0, ctl_skip = 1'b0;
  logic [12:0] ctl_target = '0;
  logic q1, q2, q3, q4, nop_out;
  logic [12:0] pc_out;
  logic [13:0] op_code;
`ifdef PIC16_STACK_STATUS_EN
  logic stk_ovf, stk_unf;
`endif
  int checks = 0;
  int errors = 0;

  pic16_fetch_sequencer dut (
    .clk(clk), .mclr(mclr), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .ctl_goto(ctl_goto), .ctl_call(ctl_call), .ctl_return(ctl_return), .ctl_skip(ctl_skip),
    .ctl_target(ctl_target), .q1(q1), .q2(q2), .q3(q3), .q4(q4),
    .pc_out(pc_out), .op_code(op_code), .nop_out(nop_out)
`ifdef PIC16_STACK_STATUS_EN
    , .stk_ovf(stk_ovf), .stk_unf(stk_unf)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: phase number, PC, IR and a modulo-8 return stack, stepped once per instruction at the Q4 edge
  logic [13:0] rom_m [1024];
  bit rom_v [1024];
  int m_ph = 0;
  int m_pc = 0;
  logic [13:0] m_ir = '0;
  bit m_irv = 1'b1;
  bit m_nop = 1'b1;
  int stk [8];
  int sp = 0;

  always @(posedge clk) begin
    if (prog_we) begin
      rom_m[prog_addr] <= prog_data;
      rom_v[prog_addr] <= 1'b1;
    end
    if (!mclr) begin
      m_ph <= 0; m_pc <= 0; m_ir <= '0; m_irv <= 1'b1; m_nop <= 1'b1; sp <= 0;
      for (int i = 0; i < 8; i++) stk[i] <= 0;
    end else if (m_ph != 4) begin
      m_ph <= m_ph + 1;
    end else begin
      m_ph <= 1;
      m_nop <= ctl_return | ctl_call | ctl_goto | ctl_skip;
      m_ir <= '0;
      m_irv <= 1'b1;
      if (ctl_return) begin
        sp <= (sp + 7) % 8;
        m_pc <= stk[(sp + 7) % 8];
      end else if (ctl_call) begin
        stk[sp] <= m_pc;
        sp <= (sp + 1) % 8;
        m_pc <= int'(ctl_target);
      end else if (ctl_goto) begin
        m_pc <= int'(ctl_target);
      end else begin
        m_pc <= (m_pc + 1) % 8192;
        if (!ctl_skip) begin
          m_ir <= rom_m[m_pc % 1024];
          m_irv <= rom_v[m_pc % 1024];
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Per-cycle compare against the model; while in clear the outputs must sit at their reset values
  always @(negedge clk) begin
    if (!mclr) begin
      chk("rst_q", 32'({q4, q3, q2, q1}), 32'd0);
      chk("rst_pc", 32'(pc_out), 32'd0);
      chk("rst_op", 32'(op_code), 32'd0);
      chk("rst_nop", 32'(nop_out), 32'd1);
    end else begin
      chk("q", 32'({q4, q3, q2, q1}), (m_ph == 0) ? 32'd0 : 32'd1 << (m_ph - 1));
      chk("pc", 32'(pc_out), 32'(m_pc));
      chk("nop", 32'(nop_out), 32'(m_nop));
      if (m_irv) chk("op", 32'(op_code), 32'(m_ir));
    end
  end

  task automatic wait_phase(input int p);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (m_ph != p && n < 16);
    if (m_ph != p) begin
      checks++;
      errors++;
      $display("FAIL wait_phase: got phase %0d expected %0d", m_ph, p);
    end
    #2;
  endtask

  task automatic wr(input logic [9:0] a, input logic [13:0] d);
    prog_addr = a;
    prog_data = d;
    prog_we = 1'b1;
    @(negedge clk);
    #2;
    prog_we = 1'b0;
  endtask

  task automatic ctl_pulse(input logic r, input logic c, input logic g, input logic s, input logic [12:0] t);
    wait_phase(4);
    {ctl_return, ctl_call, ctl_goto, ctl_skip} = {r, c, g, s};
    ctl_target = t;
    @(negedge clk);
    #2;
    {ctl_return, ctl_call, ctl_goto, ctl_skip} = 4'b0;
  endtask

  task automatic lit(input string name, input logic [13:0] op, input logic [12:0] pc, input logic nop);
    chk({name, "_op"}, 32'(op_code), 32'(op));
    chk({name, "_pc"}, 32'(pc_out), 32'(pc));
    chk({name, "_nop"}, 32'(nop_out), 32'(nop));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    #2;
    wr(10'h000, 14'h3005);
    wr(10'h001, 14'h0085);
    wr(10'h002, 14'h02B2);
    wr(10'h003, 14'h0A03);
    wr(10'h004, 14'h0804);
    wr(10'h005, 14'h2020);
    wr(10'h006, 14'h0103);
    wr(10'h010, 14'h1111);
    wr(10'h011, 14'h2222);
    wr(10'h020, 14'h0008);
    chk("hold_q", 32'({q4, q3, q2, q1}), 32'd0);
    lit("hold", 14'h0000, 13'h000, 1'b1);
    mclr = 1'b1;
    @(posedge clk);
    #1;
    chk("first_edge_q1", 32'({q4, q3, q2, q1}), 32'b0001);
    repeat (3) @(posedge clk);
    #1;
    chk("fourth_edge_q4", 32'({q4, q3, q2, q1}), 32'b1000);
    wait_phase(1);
    lit("line0", 14'h3005, 13'h001, 1'b0);
    wait_phase(1);
    lit("line1", 14'h0085, 13'h002, 1'b0);
    wait_phase(1);
    lit("line2", 14'h02B2, 13'h003, 1'b0);
    ctl_pulse(1'b0, 1'b0, 1'b1, 1'b1, 13'h010);
    lit("goto_nop", 14'h0000, 13'h010, 1'b1);
    wait_phase(1);
    lit("goto_tgt", 14'h1111, 13'h011, 1'b0);
    wait_phase(3);
    mclr = 1'b0;
    #1;
    chk("mclr_q", 32'({q4, q3, q2, q1}), 32'd0);
    lit("mclr", 14'h0000, 13'h000, 1'b1);
    @(negedge clk);
    #2;
    mclr = 1'b1;
    wait_phase(1);
    chk("restart_q1", 32'({q4, q3, q2, q1}), 32'b0001);
    lit("restart", 14'h0000, 13'h000, 1'b1);
    wait_phase(1);
    lit("re_line0", 14'h3005, 13'h001, 1'b0);
    wait_phase(1);
    wait_phase(1);
    lit("re_line2", 14'h02B2, 13'h003, 1'b0);
    wait_phase(4);
    prog_addr = 10'h003;
    prog_data = 14'h3FFF;
    prog_we = 1'b1;
    @(negedge clk);
    #2;
    prog_we = 1'b0;
    lit("rbw", 14'h0A03, 13'h004, 1'b0);
    wait_phase(2);
    ctl_goto = 1'b1;
    ctl_target = 13'h3FF;
    @(negedge clk);
    #2;
    ctl_goto = 1'b0;
    wait_phase(1);
    lit("q2_ignored", 14'h0804, 13'h005, 1'b0);
    wait_phase(1);
    lit("call_instr", 14'h2020, 13'h006, 1'b0);
    ctl_pulse(1'b0, 1'b1, 1'b0, 1'b0, 13'h020);
    lit("call_nop", 14'h0000, 13'h020, 1'b1);
    wait_phase(1);
    lit("call_tgt", 14'h0008, 13'h021, 1'b0);
    ctl_pulse(1'b1, 1'b0, 1'b0, 1'b0, 13'h000);
    lit("ret_nop", 14'h0000, 13'h006, 1'b1);
    wait_phase(1);
    lit("ret_tgt", 14'h0103, 13'h007, 1'b0);
    for (int k = 0; k < 9; k++) begin
      ctl_pulse(1'b0, 1'b1, 1'b0, 1'b0, 13'(13'h040 + k));
`ifdef PIC16_STACK_STATUS_EN
      if (k == 7) chk("ovf_at_8", 32'(stk_ovf), 32'd0);
      if (k == 8) chk("ovf_at_9", 32'(stk_ovf), 32'd1);
`endif
    end
    chk("wrap_call_pc", 32'(pc_out), 32'h048);
    for (int k = 0; k < 9; k++) begin
      ctl_pulse(1'b1, 1'b0, 1'b0, 1'b0, 13'h000);
      if (k == 0) chk("wrap_ret1_pc", 32'(pc_out), 32'h047);
      if (k == 7) chk("wrap_ret8_pc", 32'(pc_out), 32'h040);
`ifdef PIC16_STACK_STATUS_EN
      if (k == 7) chk("unf_at_8", 32'(stk_unf), 32'd0);
      if (k == 8) chk("unf_at_9", 32'(stk_unf), 32'd1);
`endif
    end
    repeat (8) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
